// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding a single 8N1 UART transmitter.
// Requesters see only req/grant; this block owns all frame timing on tx.
module uart_tx_arbiter #(
    parameter int N_REQ = 2,
    parameter int WAIT  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] data,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic               tx,
    output logic [31:0]        frame_cnt
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (WAIT > 1) ? $clog2(WAIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]       r_state;
    logic [PW-1:0]    r_ptr;
    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic [N_REQ-1:0] r_grant;
    logic             r_busy;
    logic             r_tx;
    logic [31:0]      r_frame_cnt;

    logic             w_found;
    logic [N_REQ-1:0] w_onehot;
    logic [7:0]       w_byte;
    logic [PW-1:0]    w_ptr_nxt;
    int unsigned      w_best;
    int unsigned      w_dist;

    // Winner is the requester with the smallest rotational distance from r_ptr.
    always_comb begin
        w_found   = |req;
        w_onehot  = '0;
        w_byte    = '0;
        w_ptr_nxt = '0;
        w_best    = N_REQ;
        w_dist    = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_dist = (i + N_REQ - 32'(r_ptr)) % N_REQ;
            if (req[i] && (w_dist < w_best)) begin
                w_best      = w_dist;
                w_onehot    = '0;
                w_onehot[i] = 1'b1;
                w_byte      = data[8*i +: 8];
                w_ptr_nxt   = PW'((i + 1) % N_REQ);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_grant     <= '0;
            r_busy      <= 1'b0;
            r_tx        <= 1'b1;
            r_frame_cnt <= '0;
        end else begin
            r_grant <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_onehot;
                        r_shift <= w_byte;
                        r_ptr   <= w_ptr_nxt;
                        r_busy  <= 1'b1;
                        r_tx    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            // tx already shows bit 0 of r_shift; present the next one
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt       <= '0;
                        r_busy      <= 1'b0;
                        r_frame_cnt <= r_frame_cnt + 32'd1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant     = r_grant;
    assign busy      = r_busy;
    assign tx        = r_tx;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: random bytes and request masks checked against
// a round-robin / 8N1 frame model kept at transaction level.
module tb_uart_tx_arbiter;

    localparam int N  = 2;
    localparam int W  = 8;
    localparam int FW = 10 * W;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [8*N-1:0] data;
    logic [N-1:0]   grant;
    logic           busy;
    logic           tx;
    logic [31:0]    frame_cnt;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          m_ptr = 0;
    int unsigned m_frames = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .WAIT(W)) dut (
        .clk(clk), .rst(rst), .req(req), .data(data),
        .grant(grant), .busy(busy), .tx(tx), .frame_cnt(frame_cnt)
    );

    function automatic int rr_pick(int p, logic [N-1:0] r);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(int w);
        logic [N-1:0] v;
        v = '0;
        if (w >= 0) v[w] = 1'b1;
        return v;
    endfunction

    // 8N1 line levels in time order: index 0 is the start bit, index 9 the stop bit.
    function automatic logic [9:0] frame_of(logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req = '0;
        tick;
        tick;
        rst = 1'b0;
        m_ptr = 0;
        m_frames = 0;
    endtask

    // Called in cycle 1 after a capture edge; returns in cycle 10*W+1.
    task automatic collect_frame(input logic [N-1:0] late_mask, input int late_at,
                                 output logic [9:0] bits, output bit stable,
                                 output bit busy_ok, output logic [N-1:0] gseen);
        bits = '0;
        stable = 1'b1;
        busy_ok = 1'b1;
        gseen = '0;
        for (int c = 0; c < FW; c++) begin
            if (c % W == 0) bits[c / W] = tx;
            else if (tx !== bits[c / W]) stable = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (c > 0) gseen = gseen | grant;
            if (c == late_at) req = req | late_mask;
            tick;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req = '0;
        data = '0;
        #2;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (grant !== '0) begin errors++; $display("FAIL reset_grant: got %b expected 0", grant); end
        checks++;
        if (frame_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", frame_cnt); end
        tick;
        rst = 1'b0;
        tick;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_idle: got tx=%b busy=%b expected tx=1 busy=0", tx, busy);
        end
    endtask

    task automatic test_single;
        logic [9:0] bits; bit st, bo; logic [N-1:0] gs;
        do_reset;
        data = {8'($urandom), 8'h55};
        req = 2'b01;
        tick;
        checks++;
        if (grant !== 2'b01) begin errors++; $display("FAIL single_grant: got %b expected 01", grant); end
        checks++;
        if (busy !== 1'b1 || tx !== 1'b0) begin
            errors++; $display("FAIL single_start: got busy=%b tx=%b expected busy=1 tx=0", busy, tx);
        end
        req = '0;
        m_ptr = 1;
        collect_frame('0, -1, bits, st, bo, gs);
        checks++;
        if (bits !== frame_of(8'h55)) begin errors++; $display("FAIL single_bits: got %b expected %b", bits, frame_of(8'h55)); end
        checks++;
        if (!(st && bo)) begin errors++; $display("FAIL single_timing: got stable=%b busy_held=%b expected 1 1", st, bo); end
        checks++;
        if (gs !== '0) begin errors++; $display("FAIL single_grant_pulse: got extra grant %b expected 00", gs); end
        m_frames++;
        checks++;
        if (busy !== 1'b0 || frame_cnt !== m_frames) begin
            errors++; $display("FAIL single_end: got busy=%b cnt=%0d expected busy=0 cnt=%0d", busy, frame_cnt, m_frames);
        end
    endtask

    task automatic test_contention;
        logic [9:0] bits; bit st, bo; logic [N-1:0] gs;
        int exp, last;
        logic [7:0] exp_byte;
        do_reset;
        data = {8'hB2, 8'hA1};
        req = 2'b11;
        last = -1;
        for (int f = 0; f < 5; f++) begin
            exp = rr_pick(m_ptr, req);
            exp_byte = data[8*exp +: 8];
            tick;
            checks++;
            if (grant !== onehot(exp)) begin errors++; $display("FAIL cont_grant: got %b expected %b", grant, onehot(exp)); end
            if (f > 0) begin
                checks++;
                if (cyc - last != FW + 1) begin errors++; $display("FAIL cont_spacing: got %0d expected %0d", cyc - last, FW + 1); end
            end
            last = cyc;
            m_ptr = (exp + 1) % N;
            data[8*exp +: 8] = 8'($urandom);
            collect_frame('0, -1, bits, st, bo, gs);
            checks++;
            if (bits !== frame_of(exp_byte) || !st || !bo || gs !== '0) begin
                errors++; $display("FAIL cont_frame: got bits=%b stable=%b busy=%b gs=%b expected bits=%b", bits, st, bo, gs, frame_of(exp_byte));
            end
            m_frames++;
            checks++;
            if (frame_cnt !== m_frames || busy !== 1'b0) begin
                errors++; $display("FAIL cont_count: got cnt=%0d busy=%b expected cnt=%0d busy=0", frame_cnt, busy, m_frames);
            end
        end
        req = '0;
    endtask

    task automatic test_fairness;
        logic [9:0] bits; bit st, bo; logic [N-1:0] gs;
        logic [7:0] b;
        do_reset;
        data = 16'($urandom);
        req = 2'b10;
        b = data[15:8];
        tick;
        checks++;
        if (grant !== 2'b10) begin errors++; $display("FAIL fair_first: got %b expected 10", grant); end
        m_ptr = 0;
        req = '0;
        collect_frame('0, -1, bits, st, bo, gs);
        checks++;
        if (bits !== frame_of(b) || !st || !bo) begin errors++; $display("FAIL fair_frame1: got %b expected %b", bits, frame_of(b)); end
        req = 2'b11;
        b = data[8*rr_pick(m_ptr, req) +: 8];
        tick;
        checks++;
        if (grant !== 2'b01) begin errors++; $display("FAIL fair_wrap: got %b expected 01", grant); end
        req = '0;
        collect_frame('0, -1, bits, st, bo, gs);
        checks++;
        if (bits !== frame_of(b) || !st || !bo) begin errors++; $display("FAIL fair_frame2: got %b expected %b", bits, frame_of(b)); end
        m_ptr = 1;
        m_frames = 2;
    endtask

    task automatic test_late;
        logic [9:0] bits; bit st, bo; logic [N-1:0] gs;
        logic [7:0] b;
        do_reset;
        data = 16'($urandom);
        req = 2'b01;
        tick;
        checks++;
        if (grant !== 2'b01) begin errors++; $display("FAIL late_first: got %b expected 01", grant); end
        req = '0;
        collect_frame(2'b10, 4 * W, bits, st, bo, gs);
        m_frames++;
        checks++;
        if (gs !== '0 || grant !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL late_held_off: got gs=%b grant=%b busy=%b expected 00 00 0", gs, grant, busy);
        end
        b = data[15:8];
        tick;
        checks++;
        if (grant !== 2'b10) begin errors++; $display("FAIL late_grant: got %b expected 10", grant); end
        req = '0;
        collect_frame('0, -1, bits, st, bo, gs);
        m_frames++;
        checks++;
        if (bits !== frame_of(b) || !st || !bo || frame_cnt !== m_frames) begin
            errors++; $display("FAIL late_frame: got bits=%b cnt=%0d expected bits=%b cnt=%0d", bits, frame_cnt, frame_of(b), m_frames);
        end
    endtask

    task automatic test_withdrawn;
        req = 2'b01;
        #3;
        req = '0;
        tick;
        checks++;
        if (grant !== '0 || tx !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL withdrawn_idle: got grant=%b tx=%b busy=%b expected 00 1 0", grant, tx, busy);
        end
        repeat (3) tick;
        checks++;
        if (frame_cnt !== m_frames || tx !== 1'b1) begin
            errors++; $display("FAIL withdrawn_cnt: got cnt=%0d tx=%b expected cnt=%0d tx=1", frame_cnt, tx, m_frames);
        end
    endtask

    task automatic test_reset_mid;
        logic [9:0] bits; bit st, bo; logic [N-1:0] gs;
        logic [7:0] b;
        do_reset;
        data = 16'($urandom);
        req = 2'b01;
        tick;
        req = '0;
        repeat (4 * W + 2) tick;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || frame_cnt !== 32'd0) begin
            errors++; $display("FAIL rstmid_async: got tx=%b busy=%b cnt=%0d expected 1 0 0", tx, busy, frame_cnt);
        end
        tick;
        rst = 1'b0;
        m_ptr = 0;
        m_frames = 0;
        b = data[15:8];
        req = 2'b10;
        tick;
        checks++;
        if (grant !== 2'b10) begin errors++; $display("FAIL rstmid_grant: got %b expected 10", grant); end
        req = '0;
        m_ptr = 0;
        collect_frame('0, -1, bits, st, bo, gs);
        m_frames++;
        checks++;
        if (bits !== frame_of(b) || !st || !bo || frame_cnt !== m_frames) begin
            errors++; $display("FAIL rstmid_frame: got bits=%b cnt=%0d expected bits=%b cnt=%0d", bits, frame_cnt, frame_of(b), m_frames);
        end
    endtask

    task automatic test_random;
        logic [9:0] bits; bit st, bo; logic [N-1:0] gs;
        logic [7:0] b;
        int exp;
        do_reset;
        for (int it = 0; it < 8; it++) begin
            repeat ($urandom_range(0, 3)) tick;
            checks++;
            if (grant !== '0 || busy !== 1'b0) begin errors++; $display("FAIL rand_idle: got grant=%b busy=%b expected 00 0", grant, busy); end
            data = 16'($urandom);
            req = N'($urandom_range(1, (1 << N) - 1));
            exp = rr_pick(m_ptr, req);
            b = data[8*exp +: 8];
            tick;
            checks++;
            if (grant !== onehot(exp)) begin errors++; $display("FAIL rand_grant: got %b expected %b", grant, onehot(exp)); end
            m_ptr = (exp + 1) % N;
            req = '0;
            collect_frame('0, -1, bits, st, bo, gs);
            m_frames++;
            checks++;
            if (bits !== frame_of(b) || !st || !bo || gs !== '0 || frame_cnt !== m_frames) begin
                errors++; $display("FAIL rand_frame: got bits=%b cnt=%0d expected bits=%b cnt=%0d", bits, frame_cnt, frame_of(b), m_frames);
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_contention;
        test_fairness;
        test_late;
        test_withdrawn;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
